// File: rtl/rst_pkg.sv
// Shared types for the reset sequencer: reset cause encoding and sequencer states.
package rst_pkg;

  // Source of the most recent reset; value 3 is reserved.
  typedef enum logic [1:0] {
    CAUSE_POR = 2'd0,
    CAUSE_SW  = 2'd1,
    CAUSE_BTN = 2'd2
  } rst_cause_e;

  // Sequencer phases: hold everything, release stage by stage, then idle.
  typedef enum logic [1:0] {
    HOLD    = 2'd0,
    RELEASE = 2'd1,
    RUN     = 2'd2
  } rst_seq_state_e;

  function automatic int unsigned max_u(input int unsigned a, input int unsigned b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/rst_seq_gen_if.sv
// Request/status bundle between the reset sequencer and its environment.
interface rst_seq_gen_if #(
  parameter int unsigned NUM_STAGES = 3
);
  import rst_pkg::*;

  logic                  ext_rst_btn_n;
  logic                  sw_rst_req;
  logic                  sw_rst_ack;
  logic [NUM_STAGES-1:0] rst_out_n;
  logic                  busy;
  rst_cause_e            rst_cause;

  // Environment side: drives button and software request, observes resets.
  modport master (
    output ext_rst_btn_n,
    output sw_rst_req,
    input  sw_rst_ack,
    input  rst_out_n,
    input  busy,
    input  rst_cause
  );

  // Sequencer side.
  modport slave (
    input  ext_rst_btn_n,
    input  sw_rst_req,
    output sw_rst_ack,
    output rst_out_n,
    output busy,
    output rst_cause
  );

endinterface

// File: rtl/rst_btn_debounce.sv
// Push-button path: 2-flop synchronizer, low-time debounce counter, one-cycle press pulse.
module rst_btn_debounce #(
  parameter int unsigned DEBOUNCE_CYCLES = 8
) (
  input  logic clk,
  input  logic async_rst,
  input  logic ext_rst_btn_n,
  output logic btn_press
);

  localparam int unsigned DW = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [DW-1:0] CntLast = DW'(DEBOUNCE_CYCLES - 1);
  localparam logic [DW-1:0] CntMax  = DW'(DEBOUNCE_CYCLES);

  logic          sync1_q, sync2_q;
  logic [DW-1:0] cnt_q, cnt_d;

  // Synchronize the raw button; resets to the released (high) level.
  always_ff @(posedge clk or posedge async_rst) begin
    if (async_rst) begin
      sync1_q <= 1'b1;
      sync2_q <= 1'b1;
    end else begin
      sync1_q <= ext_rst_btn_n;
      sync2_q <= sync1_q;
    end
  end

  // Count consecutive low cycles; saturate so a held button fires only once.
  always_comb begin
    cnt_d = cnt_q;
    if (sync2_q) begin
      cnt_d = '0;
    end else if (cnt_q != CntMax) begin
      cnt_d = cnt_q + DW'(1);
    end
  end

  // Debounce counter state.
  always_ff @(posedge clk or posedge async_rst) begin
    if (async_rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  // Pulse in the cycle whose closing edge brings the count to DEBOUNCE_CYCLES,
  // so the sequencer acts on that same edge. Built only from flops.
  assign btn_press = !sync2_q && (cnt_q == CntLast);

endmodule

// File: rtl/rst_seq_gen.sv
// Reset sequencer: merges POR, software and button resets, holds all stages,
// then releases rst_out_n bits one at a time, lowest first.
module rst_seq_gen
  import rst_pkg::*;
#(
  parameter int unsigned NUM_STAGES      = 3,
  parameter int unsigned HOLD_CYCLES     = 16,
  parameter int unsigned STEP_CYCLES     = 4,
  parameter int unsigned DEBOUNCE_CYCLES = 8
) (
  input  logic         clk,
  input  logic         async_rst,
  rst_seq_gen_if.slave bus
);

  localparam int unsigned CW = $clog2(max_u(HOLD_CYCLES, STEP_CYCLES) + 1);
  localparam int unsigned IW = $clog2(NUM_STAGES + 1);
  localparam logic [CW-1:0] HoldLast = CW'(HOLD_CYCLES - 1);
  localparam logic [CW-1:0] StepLast = CW'(STEP_CYCLES - 1);
  localparam logic [IW-1:0] IdxLast  = IW'(NUM_STAGES - 1);

  rst_seq_state_e        state_q, state_d;
  logic [CW-1:0]         ctr_q, ctr_d;
  logic [IW-1:0]         idx_q, idx_d;
  logic [NUM_STAGES-1:0] rst_out_n_q, rst_out_n_d;
  logic                  busy_q, busy_d;
  logic                  ack_q, ack_d;
  rst_cause_e            cause_q, cause_d;
  logic                  armed_q, armed_d;

  logic btn_press;
  logic sw_accept;
  logic req;

  rst_btn_debounce #(
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
  ) u_btn (
    .clk          (clk),
    .async_rst    (async_rst),
    .ext_rst_btn_n(bus.ext_rst_btn_n),
    .btn_press    (btn_press)
  );

  // A sw request is consumed even when a button press wins the cause.
  assign sw_accept = bus.sw_rst_req && armed_q;
  assign req       = btn_press || sw_accept;

  // Next-state: any request restarts HOLD; otherwise walk HOLD -> RELEASE -> RUN.
  always_comb begin
    state_d     = state_q;
    ctr_d       = ctr_q;
    idx_d       = idx_q;
    rst_out_n_d = rst_out_n_q;
    busy_d      = busy_q;
    cause_d     = cause_q;
    ack_d       = sw_accept;
    armed_d     = armed_q;

    if (sw_accept) begin
      armed_d = 1'b0;
    end else if (!bus.sw_rst_req) begin
      armed_d = 1'b1;
    end

    if (req) begin
      state_d     = HOLD;
      ctr_d       = '0;
      idx_d       = '0;
      rst_out_n_d = '0;
      busy_d      = 1'b1;
      cause_d     = btn_press ? CAUSE_BTN : CAUSE_SW;
    end else begin
      unique case (state_q)
        HOLD: begin
          if (ctr_q == HoldLast) begin
            rst_out_n_d[0] = 1'b1;
            ctr_d          = '0;
            if (NUM_STAGES == 1) begin
              state_d = RUN;
              busy_d  = 1'b0;
            end else begin
              state_d = RELEASE;
              idx_d   = IW'(1);
            end
          end else begin
            ctr_d = ctr_q + CW'(1);
          end
        end
        RELEASE: begin
          if (ctr_q == StepLast) begin
            for (int unsigned i = 0; i < NUM_STAGES; i++) begin
              if (idx_q == IW'(i)) rst_out_n_d[i] = 1'b1;
            end
            ctr_d = '0;
            idx_d = idx_q + IW'(1);
            if (idx_q == IdxLast) begin
              state_d = RUN;
              busy_d  = 1'b0;
            end
          end else begin
            ctr_d = ctr_q + CW'(1);
          end
        end
        RUN: begin
        end
        default: begin
          state_d     = HOLD;
          ctr_d       = '0;
          idx_d       = '0;
          rst_out_n_d = '0;
          busy_d      = 1'b1;
        end
      endcase
    end
  end

  // Sequencer state; async_rst is the power-on source.
  always_ff @(posedge clk or posedge async_rst) begin
    if (async_rst) begin
      state_q     <= HOLD;
      ctr_q       <= '0;
      idx_q       <= '0;
      rst_out_n_q <= '0;
      busy_q      <= 1'b1;
      ack_q       <= 1'b0;
      cause_q     <= CAUSE_POR;
      armed_q     <= 1'b1;
    end else begin
      state_q     <= state_d;
      ctr_q       <= ctr_d;
      idx_q       <= idx_d;
      rst_out_n_q <= rst_out_n_d;
      busy_q      <= busy_d;
      ack_q       <= ack_d;
      cause_q     <= cause_d;
      armed_q     <= armed_d;
    end
  end

  assign bus.rst_out_n  = rst_out_n_q;
  assign bus.busy       = busy_q;
  assign bus.sw_rst_ack = ack_q;
  assign bus.rst_cause  = cause_q;

endmodule

// File: tb/tb_rst_seq_gen.sv
// Scoreboard bench for rst_seq_gen: stimulus queues expected output-change events,
// a negedge monitor pops one per observed change and compares.
module tb_rst_seq_gen;
  import rst_pkg::*;

  typedef struct {
    int         cyc;
    logic [2:0] out;
    logic       busy;
    rst_cause_e cause;
    logic       ack;
  } ev_t;

  logic clk = 1'b0;
  logic async_rst;
  int   cyc = 0;
  int   checks = 0;
  int   errors = 0;
  ev_t  exp_q[$];

  rst_seq_gen_if #(.NUM_STAGES(3)) bus ();

  rst_seq_gen #(
    .NUM_STAGES     (3),
    .HOLD_CYCLES    (16),
    .STEP_CYCLES    (4),
    .DEBOUNCE_CYCLES(8)
  ) dut (
    .clk      (clk),
    .async_rst(async_rst),
    .bus      (bus)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic push_ev(input int c, input logic [2:0] o, input logic b, input rst_cause_e ca,
                         input logic a);
    ev_t e;
    e.cyc = c; e.out = o; e.busy = b; e.cause = ca; e.ack = a;
    exp_q.push_back(e);
  endtask

  // Request accepted at edge e: outputs drop; ack visible for the following cycle only.
  task automatic push_req(input int e, input rst_cause_e ca, input logic acked);
    push_ev(e, 3'b000, 1'b1, ca, acked);
    if (acked) push_ev(e + 1, 3'b000, 1'b1, ca, 1'b0);
  endtask

  // First n stage releases of a sequence started at edge s.
  task automatic push_rel(input int s, input int n, input rst_cause_e ca);
    logic [2:0] o;
    o = 3'b000;
    for (int i = 0; i < n; i++) begin
      o[i] = 1'b1;
      push_ev(s + 16 + 4 * i, o, (i != 2), ca, 1'b0);
    end
  endtask

  task automatic wait_to(input int n);
    while (cyc < n) @(negedge clk);
  endtask

  // Monitor: every change of the observable outputs must match the next expected event.
  initial begin
    logic [6:0] prev;
    logic [6:0] cur;
    ev_t        e;
    prev = 'x;
    forever begin
      @(negedge clk);
      cur = {bus.rst_out_n, bus.busy, bus.rst_cause, bus.sw_rst_ack};
      if (cur !== prev) begin
        checks++;
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL unexpected_event: got cyc=%0d out=%b busy=%b cause=%0d ack=%b, want none",
                   cyc, bus.rst_out_n, bus.busy, bus.rst_cause, bus.sw_rst_ack);
        end else begin
          e = exp_q.pop_front();
          if (e.cyc != cyc || e.out !== bus.rst_out_n || e.busy !== bus.busy ||
              e.cause !== bus.rst_cause || e.ack !== bus.sw_rst_ack) begin
            errors++;
            $display("FAIL event: got cyc=%0d out=%b busy=%b cause=%0d ack=%b, want cyc=%0d out=%b busy=%b cause=%0d ack=%b",
                     cyc, bus.rst_out_n, bus.busy, bus.rst_cause, bus.sw_rst_ack,
                     e.cyc, e.out, e.busy, e.cause, e.ack);
          end
        end
        prev = cur;
      end
    end
  end

  initial begin
    async_rst         = 1'b1;
    bus.ext_rst_btn_n = 1'b1;
    bus.sw_rst_req    = 1'b0;

    // 1. POR held for 3 edges; spec edge 1 is absolute edge 4.
    push_ev(1, 3'b000, 1'b1, CAUSE_POR, 1'b0);
    push_rel(3, 3, CAUSE_POR);
    repeat (3) @(negedge clk);
    async_rst = 1'b0;

    // 2. SW request held 10 cycles in RUN, then a second request after re-arm.
    wait_to(30);
    bus.sw_rst_req = 1'b1;
    push_req(31, CAUSE_SW, 1'b1);
    push_rel(31, 3, CAUSE_SW);
    wait_to(40);
    bus.sw_rst_req = 1'b0;
    wait_to(60);
    bus.sw_rst_req = 1'b1;
    push_req(61, CAUSE_SW, 1'b1);
    push_rel(61, 3, CAUSE_SW);
    wait_to(64);
    bus.sw_rst_req = 1'b0;

    // 3. Short glitch ignored; 20-cycle press fires 10 edges after the fall.
    wait_to(90);
    bus.ext_rst_btn_n = 1'b0;
    wait_to(95);
    bus.ext_rst_btn_n = 1'b1;
    wait_to(110);
    bus.ext_rst_btn_n = 1'b0;
    push_req(120, CAUSE_BTN, 1'b0);
    push_rel(120, 3, CAUSE_BTN);
    wait_to(130);
    bus.ext_rst_btn_n = 1'b1;

    // 4. Second SW request 22 edges into a sequence reasserts released stages.
    wait_to(150);
    bus.sw_rst_req = 1'b1;
    push_req(151, CAUSE_SW, 1'b1);
    push_rel(151, 2, CAUSE_SW);
    wait_to(155);
    bus.sw_rst_req = 1'b0;
    wait_to(172);
    bus.sw_rst_req = 1'b1;
    push_req(173, CAUSE_SW, 1'b1);
    push_rel(173, 3, CAUSE_SW);
    wait_to(176);
    bus.sw_rst_req = 1'b0;

    // 5. Button press pulse and SW request on the same edge.
    wait_to(210);
    bus.ext_rst_btn_n = 1'b0;
    wait_to(219);
    bus.sw_rst_req = 1'b1;
    push_req(220, CAUSE_BTN, 1'b1);
    push_rel(220, 3, CAUSE_BTN);
    wait_to(225);
    bus.sw_rst_req = 1'b0;
    wait_to(240);
    bus.ext_rst_btn_n = 1'b1;

    // 6. async_rst between edges while stages 0-1 are released.
    wait_to(260);
    bus.sw_rst_req = 1'b1;
    push_req(261, CAUSE_SW, 1'b1);
    push_rel(261, 2, CAUSE_SW);
    wait_to(264);
    bus.sw_rst_req = 1'b0;
    wait_to(282);
    #2;
    async_rst = 1'b1;
    push_ev(283, 3'b000, 1'b1, CAUSE_POR, 1'b0);
    #1;
    checks++;
    if (bus.rst_out_n !== 3'b000 || bus.busy !== 1'b1 || bus.rst_cause !== CAUSE_POR) begin
      errors++;
      $display("FAIL async_assert: got out=%b busy=%b cause=%0d, want out=000 busy=1 cause=0",
               bus.rst_out_n, bus.busy, bus.rst_cause);
    end
    wait_to(285);
    async_rst = 1'b0;
    push_rel(285, 3, CAUSE_POR);

    wait_to(330);
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL missing_events: got %0d outstanding, want 0 (next cyc=%0d)",
               exp_q.size(), exp_q[0].cyc);
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/rst_seq_gen.md
Name: rst_seq_gen

Overview:
Reset sequencer and generator in the always-on clock domain. It merges power-on, software and push-button reset sources, holds reset for a minimum width, then releases NUM_STAGES reset outputs in a fixed order. Each rst_out_n bit is a registered, glitch-free, active-low reset. Each bit drives the async_rst_n input of one per-domain reset synchronizer.

Parameters:
NUM_STAGES, 3, number of sequenced reset outputs; must be >= 1.
HOLD_CYCLES, 16, clk edges that all outputs stay asserted before the first release; must be >= 1.
STEP_CYCLES, 4, clk edges between consecutive stage releases; must be >= 1.
DEBOUNCE_CYCLES, 8, consecutive synchronized-low cycles that qualify a button press; must be >= 1.

Ports:
clk  input  1  system clock; all state on rising edge.
async_rst  input  1  asynchronous, active-high reset. Treated as the power-on source.
ext_rst_btn_n  input  1  raw, asynchronous, active-low push-button.
sw_rst_req  input  1  software reset request; level, held until acknowledged.
sw_rst_ack  output  1  one-cycle pulse; the request has been accepted.
rst_out_n  output  NUM_STAGES  sequenced active-low resets; bit 0 is released first.
busy  output  1  high while any stage is still held in reset.
rst_cause  output  2  source of the most recent reset (rst_cause_e).

Behaviour:
- Reset: one clock, clk. Reset is asynchronous and active-high on async_rst. While async_rst is high:
  - state = HOLD, counter = 0, stage index = 0
  - rst_out_n = all 0, busy = 1, sw_rst_ack = 0, rst_cause = CAUSE_POR
  - button path cleared, sw request armed
- Edge numbering: the first rising edge after async_rst falls is edge 1.
- HOLD state:
  - counter increments each edge.
  - On the HOLD_CYCLES-th edge: rst_out_n[0] := 1, counter := 0, go to RELEASE (index 1).
  - If NUM_STAGES == 1, go straight to RUN and drop busy on that same edge.
- RELEASE state:
  - On every STEP_CYCLES-th edge, release rst_out_n[index] and increment index.
  - The edge that releases bit NUM_STAGES-1 also sets busy := 0 and enters RUN.
  - Defaults give releases at edges 16, 20, 24; busy falls at edge 24.
- RUN state: idle. busy = 0, rst_out_n = all 1.
- Reset request: a qualified button press or an armed sw_rst_req sampled high at edge E.
  - Valid in any state.
  - At E: rst_out_n := all 0, busy := 1, counter := 0, index := 0, state := HOLD.
  - The sequence then repeats relative to E: stage 0 releases at E+HOLD_CYCLES.
  - A request during HOLD or RELEASE restarts HOLD from 0; outputs already released are reasserted.
- Cause priority: button > sw. rst_cause is updated at E. CAUSE_POR is set only by async_rst.
- sw handshake:
  - An armed, high sw_rst_req is accepted at E.
  - sw_rst_ack is high for exactly the cycle after E, and the request is disarmed.
  - Re-arm only after sw_rst_req is sampled low, so a held request never retriggers.
  - If button and sw coincide, the sw request is still consumed and acked; rst_cause = CAUSE_BTN.
- Button path:
  - 2-flop synchronizer, then debounce counter.
  - Counter increments while the synced value is low and clears when high.
  - One-cycle press pulse when the count reaches DEBOUNCE_CYCLES; saturate afterwards.
  - Another press is not recognised until the synced value has been seen high.
  - Latency from raw falling edge to request: 2 + DEBOUNCE_CYCLES edges.
  - Glitches shorter than DEBOUNCE_CYCLES cause no reset.
- Counter widths:
  - Sequencing counter: $clog2(max(HOLD_CYCLES,STEP_CYCLES)+1) bits.
  - Debounce counter: $clog2(DEBOUNCE_CYCLES+1) bits.
  - Index: $clog2(NUM_STAGES+1) bits.
  - No wrap is reachable.
- All outputs are driven directly from flops; no combinational paths from inputs.

Decomposition:
- Package rst_pkg:
  - rst_cause_e (2-bit): CAUSE_POR=0, CAUSE_SW=1, CAUSE_BTN=2, value 3 reserved.
  - rst_seq_state_e: HOLD, RELEASE, RUN.
- Sub-module rst_btn_debounce: synchronizer, debounce counter and press-pulse generation, with the same clk/async_rst. Parameter DEBOUNCE_CYCLES; output btn_press.

Test Plan:
1. POR: hold async_rst 3 cycles, then release (defaults) -> rst_out_n = 000 up to edge 15; 001 at 16, 011 at 20, 111 at 24; busy falls at 24; rst_cause = POR.
2. SW request in RUN: raise sw_rst_req at edge E, hold 10 cycles -> rst_out_n = 000 after E; ack pulses only in cycle E+1; one reset sequence only (001 at E+16); rst_cause = SW. Drop then re-raise the request -> a second reset.
3. Button glitch and press: ext_rst_btn_n low 5 cycles -> no effect. Low 20 cycles -> request at edge 2+8 after the fall; exactly one sequence; rst_cause = BTN.
4. Mid-sequence request: SW request at edge 22 (stages 0-1 released) -> all reasserted; 001 at 38, 111 at 46.
5. Simultaneous: button press pulse and sw_rst_req in the same cycle -> rst_cause = BTN, sw_rst_ack pulses, single sequence.
6. Async reset mid-RELEASE: assert async_rst between clock edges -> rst_out_n = 000 immediately, without waiting for a clock edge; rst_cause = POR; sequence restarts from edge 1.
